ttl_decoder_scan: RTL

Registered, scanning multi-block decoder/demultiplexer with inverted outputs. It extends the dual 2-to-4 decoder to BLOCKS independent channels of WIDTH_OUT outputs each. Each channel holds its own address register, loaded from a shared bus or auto-incremented in scan mode. It sits in the 7400-family library as the driver for multiplexed displays and keyboard-matrix strobes.

---
 rtl/ttl_decoder_scan_pkg.sv | 14 +
 rtl/ttl_decoder_scan_channel.sv | 41 ++++
 rtl/ttl_decoder_scan.sv | 47 ++++
 3 files changed

// File: rtl/ttl_decoder_scan_pkg.sv
// ttl_decoder_scan_pkg: shared helpers for the scanning decoder; supplies the PACK_ARRAY flattening macro
`ifndef PACK_ARRAY
`define PACK_ARRAY(W, N, SRC, DST) \
  for (genvar p = 0; p < (N); p++) begin : g_pack \
    assign DST[p*(W) +: (W)] = SRC[p]; \
  end
`endif

package ttl_decoder_scan_pkg;
  // True when a scan step from addr must return to 0 (last valid index or out of range)
  function automatic bit at_or_past_last(int addr, int width_out);
    return addr >= width_out - 1;
  endfunction
endpackage

// File: rtl/ttl_decoder_scan_channel.sv
// ttl_decoder_scan_channel: one address register with inverted one-hot decode; blanking under TTL_DECODER_SCAN_BLANK_EN
module ttl_decoder_scan_channel
  import ttl_decoder_scan_pkg::*;
#(
  parameter int WIDTH_OUT = 4,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic                 Clk,
  input  logic                 Clear,
  input  logic                 Load,
  input  logic                 Scan,
  input  logic                 Enable_bar,
  input  logic [WIDTH_IN-1:0]  A,
  output logic [WIDTH_OUT-1:0] Y,
  output logic                 Wrap_stb
);
  logic [WIDTH_IN-1:0] addr_q, addr_d;
  logic                at_end;
  logic                blank_q;
  // Load beats Scan; a scan step from the last or any out-of-range address returns to 0
  always_comb begin
    at_end   = at_or_past_last(int'(addr_q), WIDTH_OUT);
    addr_d   = Load ? A : Scan ? (at_end ? '0 : addr_q + 1'b1) : addr_q;
    Wrap_stb = Scan && !Load && at_end;
  end
  // Address register with synchronous clear
  always_ff @(posedge Clk) addr_q <= Clear ? '0 : addr_d;
`ifdef TTL_DECODER_SCAN_BLANK_EN
  logic blank_d;
  // Blank for one cycle after any address write so outputs break before make
  always_comb blank_d = Load || Scan;
  // Blank register, cleared by Clear
  always_ff @(posedge Clk) blank_q <= Clear ? 1'b0 : blank_d;
`else
  assign blank_q = 1'b0;
`endif
  // Active-low one-hot decode; out-of-range addresses match no output
  always_comb
    for (int i = 0; i < WIDTH_OUT; i++)
      Y[i] = !(!Enable_bar && !blank_q && addr_q == WIDTH_IN'(i));
endmodule

// File: rtl/ttl_decoder_scan.sv
// ttl_decoder_scan: BLOCKS scanning inverted decoders with channel-0 wrap pulse; optional blanking via TTL_DECODER_SCAN_BLANK_EN
module ttl_decoder_scan
  import ttl_decoder_scan_pkg::*;
#(
  parameter int BLOCKS     = 2,
  parameter int WIDTH_OUT  = 4,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                        Clk,
  input  logic                        Clear,
  input  logic [BLOCKS-1:0]           Load,
  input  logic                        Scan,
  input  logic [BLOCKS-1:0]           Enable_bar,
  input  logic [WIDTH_IN-1:0]         A,
  output logic [BLOCKS*WIDTH_OUT-1:0] Y_2D,
  output logic                        Wrap
);
  logic [WIDTH_OUT-1:0]        y_ch [BLOCKS];
  logic [BLOCKS*WIDTH_OUT-1:0] y_flat, y_rise, y_fall;
  logic                        wrap_stb0;
  logic                        wrap_q, wrap_d;
  for (genvar b = 0; b < BLOCKS; b++) begin : g_ch
    if (b == 0) begin : g_first
      ttl_decoder_scan_channel #(.WIDTH_OUT(WIDTH_OUT), .WIDTH_IN(WIDTH_IN)) u_ch (
        .Clk(Clk), .Clear(Clear), .Load(Load[b]), .Scan(Scan), .Enable_bar(Enable_bar[b]),
        .A(A), .Y(y_ch[b]), .Wrap_stb(wrap_stb0)
      );
    end else begin : g_rest
      ttl_decoder_scan_channel #(.WIDTH_OUT(WIDTH_OUT), .WIDTH_IN(WIDTH_IN)) u_ch (
        .Clk(Clk), .Clear(Clear), .Load(Load[b]), .Scan(Scan), .Enable_bar(Enable_bar[b]),
        .A(A), .Y(y_ch[b]), .Wrap_stb()
      );
    end
  end
  `PACK_ARRAY(WIDTH_OUT, BLOCKS, y_ch, y_flat)
  // Wrap follows channel 0's scan wrap strobe
  always_comb wrap_d = wrap_stb0;
  // Wrap pulse register with synchronous clear
  always_ff @(posedge Clk) wrap_q <= Clear ? 1'b0 : wrap_d;
  assign Wrap = wrap_q;
  // Rising bits take the rise-delayed copy, falling bits the fall-delayed copy
  assign #(DELAY_RISE) y_rise = y_flat;
  assign #(DELAY_FALL) y_fall = y_flat;
  assign Y_2D = (y_flat & y_rise) | (~y_flat & y_fall);
endmodule
